// File: rtl/md_unit_p.sv
// Parametrised multiply/divide unit with HI/LO registers; results commit on completion.
// Optional multiply-accumulate (opcodes 9-12) is enabled by defining MDU_MACC_EN.
module md_unit_p #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] numa,
   input  logic [WIDTH-1:0] numb,
   input  logic [3:0]       op_d,
   input  logic [3:0]       op_e,
   output logic             busy,
   output logic             xstall,
   output logic [WIDTH-1:0] xaluout
);

   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);
   localparam int unsigned W2      = 2 * WIDTH;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MTLO  = 4'd1,
      OP_MTHI  = 4'd2,
      OP_DIVU  = 4'd3,
      OP_DIV   = 4'd4,
      OP_MULTU = 4'd5,
      OP_MULT  = 4'd6,
      OP_MFLO  = 4'd7,
      OP_MFHI  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } op_t;

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic is_mul, is_div, is_sgn;
`ifdef MDU_MACC_EN
   logic is_acc, is_sub;
`endif

   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      is_sgn = 1'b0;
`ifdef MDU_MACC_EN
      is_acc = 1'b0;
      is_sub = 1'b0;
`endif
      case (op_e)
         OP_DIVU:  is_div = 1'b1;
         OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
         OP_MULTU: is_mul = 1'b1;
         OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
`ifdef MDU_MACC_EN
         OP_MADD:  begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; end
         OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
         OP_MSUB:  begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
         OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
         default: ;
      endcase
   end

   // Sign-extending to 2*WIDTH makes the truncated product the exact signed product.
   logic [W2-1:0] ext_a, ext_b, prod;
   always_comb begin
      ext_a = is_sgn ? {{WIDTH{numa[WIDTH-1]}}, numa} : {{WIDTH{1'b0}}, numa};
      ext_b = is_sgn ? {{WIDTH{numb[WIDTH-1]}}, numb} : {{WIDTH{1'b0}}, numb};
      prod  = ext_a * ext_b;
   end

   // One unsigned divider on magnitudes serves both div and divu.
   logic             a_neg, b_neg, div_zero, div_ovf;
   logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, div_lo, div_hi;
   always_comb begin
      a_neg    = is_sgn & numa[WIDTH-1];
      b_neg    = is_sgn & numb[WIDTH-1];
      a_mag    = a_neg ? ('0 - numa) : numa;
      b_mag    = b_neg ? ('0 - numb) : numb;
      div_zero = (numb == '0);
      div_ovf  = is_sgn && (numa == {1'b1, {(WIDTH-1){1'b0}}}) && (numb == '1);
      q_mag    = '0;
      r_mag    = '0;
      if (!div_zero) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      if (div_zero) begin
         div_lo = '1;
         div_hi = numa;
      end else if (div_ovf) begin
         div_lo = numa;
         div_hi = '0;
      end else begin
         div_lo = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
         div_hi = a_neg ? ('0 - r_mag) : r_mag;
      end
   end

   logic [W2-1:0] mul_res, result;
   always_comb begin
      mul_res = prod;
`ifdef MDU_MACC_EN
      if (is_acc)
         mul_res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
      result = is_div ? {div_hi, div_lo} : mul_res;
   end

   logic start;
   assign busy  = (cnt_q != '0);
   assign start = !busy && (is_mul || is_div);

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      phi_d = phi_q;
      plo_d = plo_q;
      cnt_d = cnt_q;
      if (busy) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            hi_d = phi_q;
            lo_d = plo_q;
         end
      end else if (start) begin
         cnt_d = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
         phi_d = result[W2-1:WIDTH];
         plo_d = result[WIDTH-1:0];
      end else if (op_e == OP_MTHI) begin
         hi_d = numa;
      end else if (op_e == OP_MTLO) begin
         lo_d = numa;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         phi_q <= '0;
         plo_q <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         phi_q <= phi_d;
         plo_q <= plo_d;
         cnt_q <= cnt_d;
      end
   end

   logic d_uses_mdu;
`ifdef MDU_MACC_EN
   assign d_uses_mdu = (op_d != OP_NONE) && (op_d <= OP_MSUBU);
`else
   assign d_uses_mdu = (op_d != OP_NONE) && (op_d <= OP_MFHI);
`endif
   assign xstall = d_uses_mdu && (busy || is_mul || is_div);

   always_comb begin
      case (op_e)
         OP_MFHI: xaluout = hi_q;
         OP_MFLO: xaluout = lo_q;
         default: xaluout = '0;
      endcase
   end

endmodule

// File: tb/tb_md_unit_p.sv
// Directed self-checking bench for md_unit_p (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
module tb_md_unit_p;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] numa, numb;
   logic [3:0]  op_d, op_e;
   logic        busy, xstall;
   logic [31:0] xaluout;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   md_unit_p #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .numa    (numa),
      .numb    (numb),
      .op_d    (op_d),
      .op_e    (op_e),
      .busy    (busy),
      .xstall  (xstall),
      .xaluout (xaluout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      numa = a;
      numb = b;
      op_e = op;
      tick();
      op_e = 4'd0;
   endtask

   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      op_e = 4'd8;
      #1 h = xaluout;
      op_e = 4'd7;
      #1 l = xaluout;
      op_e = 4'd0;
      #1;
   endtask

   // Counts edges until busy drops, bounded so a stuck unit cannot hang the run.
   task automatic wait_done(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] h, l;
      reset = 1'b1; op_e = 4'd0; op_d = 4'd0; numa = '0; numb = '0;
      tick(); tick();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      op_d = 4'd7; #1;
      n_chk++; if (xstall !== 1'b0) begin n_fail++; $display("FAIL reset_xstall: got %b expected 0", xstall); end
      op_d = 4'd0;
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", h); end
      n_chk++; if (l !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", l); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      logic [31:0] h, l;
      int n;
      issue(4'd6, 32'hFFFF_FFFD, 32'd7);
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy[%0d]: got %b expected 1", i, busy); end
         read_hilo(h, l);
         n_chk++; if (h !== 32'h0 || l !== 32'h0) begin n_fail++; $display("FAIL mult_hold[%0d]: got %h_%h expected 00000000_00000000", i, h, l); end
         tick();
      end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_done: busy got %b expected 0", busy); end
      read_hilo(h, l);
      n_chk++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", h); end
      n_chk++; if (l !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", l); end

      issue(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(n);
      n_chk++; if (n != 5) begin n_fail++; $display("FAIL multu_lat: got %0d expected 5", n); end
      read_hilo(h, l);
      n_chk++; if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_res: got %h_%h expected fffffffe_00000001", h, l); end
   endtask

   task automatic test_div();
      logic [31:0] h, l;
      int n;
      issue(4'd4, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      n_chk++; if (n != 10) begin n_fail++; $display("FAIL div_lat: got %0d expected 10", n); end
      read_hilo(h, l);
      n_chk++; if (l !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", l); end
      n_chk++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", h); end

      issue(4'd4, 32'd7, 32'hFFFF_FFFE);
      wait_done(n);
      read_hilo(h, l);
      n_chk++; if (h !== 32'h1 || l !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_pos_neg: got %h_%h expected 00000001_fffffffd", h, l); end

      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      read_hilo(h, l);
      n_chk++; if (h !== 32'h1 || l !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_res: got %h_%h expected 00000001_7ffffffc", h, l); end
   endtask

   task automatic test_div_corner();
      logic [31:0] h, l;
      int n;
      issue(4'd3, 32'd5, 32'd0);
      wait_done(n);
      read_hilo(h, l);
      n_chk++; if (h !== 32'd5 || l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero: got %h_%h expected 00000005_ffffffff", h, l); end

      issue(4'd4, 32'hFFFF_FFF9, 32'd0);
      wait_done(n);
      read_hilo(h, l);
      n_chk++; if (h !== 32'hFFFF_FFF9 || l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero: got %h_%h expected fffffff9_ffffffff", h, l); end

      issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n);
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0 || l !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h_%h expected 00000000_80000000", h, l); end
   endtask

   task automatic test_xstall();
      int n;
      numa = 32'd2; numb = 32'd3;
      op_d = 4'd7; op_e = 4'd6; #1;
      n_chk++; if (xstall !== 1'b1) begin n_fail++; $display("FAIL xstall_start: got %b expected 1", xstall); end
      tick();
      op_e = 4'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_chk++; if (xstall !== 1'b1) begin n_fail++; $display("FAIL xstall_busy[%0d]: got %b expected 1", i, xstall); end
         tick();
      end
      #1;
      n_chk++; if (xstall !== 1'b0) begin n_fail++; $display("FAIL xstall_after: got %b expected 0", xstall); end

      op_d = 4'd0; op_e = 4'd6; #1;
      n_chk++; if (xstall !== 1'b0) begin n_fail++; $display("FAIL xstall_nod_start: got %b expected 0", xstall); end
      tick();
      op_e = 4'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_chk++; if (xstall !== 1'b0) begin n_fail++; $display("FAIL xstall_nod_busy[%0d]: got %b expected 0", i, xstall); end
         tick();
      end
      wait_done(n);
   endtask

   task automatic test_busy_ignore();
      logic [31:0] h, l;
      int n;
      issue(4'd6, 32'd4, 32'd5);
      numa = 32'hDEAD_BEEF; op_e = 4'd2; tick();
      numa = 32'd9; numb = 32'd1; op_e = 4'd4; tick();
      numa = 32'h1234_0000; op_e = 4'd1; tick();
      op_e = 4'd0;
      wait_done(n);
      n_chk++; if (n != 2) begin n_fail++; $display("FAIL ignore_lat: got %0d expected 2", n); end
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0 || l !== 32'd20) begin n_fail++; $display("FAIL ignore_res: got %h_%h expected 00000000_00000014", h, l); end

      issue(4'd2, 32'h1234_5678, 32'd0);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", busy); end
      issue(4'd1, 32'h9ABC_DEF0, 32'd0);
      read_hilo(h, l);
      n_chk++; if (h !== 32'h1234_5678 || l !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mthi_mtlo: got %h_%h expected 12345678_9abcdef0", h, l); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] h, l;
      issue(4'd4, 32'd100, 32'd7);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0 || l !== 32'h0) begin n_fail++; $display("FAIL rstmid_clear: got %h_%h expected 00000000_00000000", h, l); end
      for (int i = 0; i < 12; i++) tick();
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0 || l !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_nocommit: got %h_%h busy %b expected 00000000_00000000 busy 0", h, l, busy); end
   endtask

   task automatic test_macc();
      logic [31:0] h, l;
      int n;
`ifdef MDU_MACC_EN
      issue(4'd2, 32'd0, 32'd0);
      issue(4'd1, 32'd10, 32'd0);
      issue(4'd9, 32'd3, 32'd4);
      wait_done(n);
      n_chk++; if (n != 5) begin n_fail++; $display("FAIL madd_lat: got %0d expected 5", n); end
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0 || l !== 32'd22) begin n_fail++; $display("FAIL madd_res: got %h_%h expected 00000000_00000016", h, l); end
      issue(4'd12, 32'd1, 32'd22);
      wait_done(n);
      read_hilo(h, l);
      n_chk++; if (h !== 32'h0 || l !== 32'h0) begin n_fail++; $display("FAIL msubu_res: got %h_%h expected 00000000_00000000", h, l); end
`else
      issue(4'd2, 32'h11, 32'd0);
      issue(4'd1, 32'h22, 32'd0);
      op_d = 4'd7; numa = 32'd3; numb = 32'd4; op_e = 4'd9; #1;
      n_chk++; if (xstall !== 1'b0) begin n_fail++; $display("FAIL nomacc_xstall: got %b expected 0", xstall); end
      tick();
      op_e = 4'd0; op_d = 4'd0;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nomacc_busy: got %b expected 0", busy); end
      tick(); tick();
      read_hilo(h, l);
      n_chk++; if (h !== 32'h11 || l !== 32'h22) begin n_fail++; $display("FAIL nomacc_hold: got %h_%h expected 00000011_00000022", h, l); end
      n = 0;
`endif
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_corner();
      test_xstall();
      test_busy_ignore();
      test_reset_mid();
      test_macc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/md_unit_p.md
Name: md_unit_p

Overview:
- Parametrised multiply/divide unit with HI/LO registers; successor to the fixed 32-bit MDU.
- Sits beside the main ALU in EX. Takes operands and an EX-stage opcode; reports a decode-stage stall while busy; returns HI/LO on mfhi/mflo.
- New over the previous generation:
  - Configurable width and latencies.
  - Results are committed only when the operation completes.
  - Defined divide-by-zero and overflow results.
  - Optional multiply-accumulate.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MUL_LAT, 5: busy cycles for mult/multu (and madd family); must be >=1.
- DIV_LAT, 10: busy cycles for div/divu; must be >=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- numa  in  WIDTH  operand A (rs)
- numb  in  WIDTH  operand B (rt)
- op_d  in  4  opcode of the instruction in decode
- op_e  in  4  opcode of the instruction in EX
- busy  out  1  operation in flight
- xstall  out  1  stall request to decode
- xaluout  out  WIDTH  HI/LO read data

Behaviour:
- Opcodes:
  - 0 none, 1 mtlo, 2 mthi, 3 divu, 4 div, 5 multu, 6 mult, 7 mflo, 8 mfhi
  - 9 madd, 10 maddu, 11 msub, 12 msubu (feature-gated)
  - 13-15 treated as 0
- Reset: hi=0, lo=0, counter=0, pending result=0, busy=0, xstall=0. Reset mid-operation aborts the operation: HI/LO go to 0 and no commit occurs.
- busy = (counter != 0). Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1).
- xstall = (op_d in 1..12) && (busy || op_e in {3,4,5,6,9..12}), combinational. The second term covers a start in the current cycle.
- Start, at a posedge with busy=0 and op_e a mul/div op:
  - Counter loads MUL_LAT or DIV_LAT.
  - The full result is computed into pending hi/lo registers.
  - hi/lo keep their old values.
- Each cycle with counter>0: decrement. On the edge where counter goes 1->0, pending is copied to hi/lo.
- Timing: start at edge N; busy is high for cycles N..N+LAT-1. From edge N+LAT, busy=0 and new HI/LO are visible.
- mult: signed 2*WIDTH product. multu: unsigned 2*WIDTH product. Result is {hi,lo}.
- div/divu: lo=quotient, hi=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = numa, for both signed and unsigned.
- Signed overflow (numa = most negative value, numb = -1): lo = numa, hi = 0.
- madd/maddu: pending = {hi,lo} + product. msub/msubu: pending = {hi,lo} - product. Arithmetic is modulo 2^(2*WIDTH); {hi,lo} is sampled at start.
- mthi/mtlo with busy=0: write numa at that edge. There is no counter change and no latency.
- Any mul/div/mthi/mtlo presented in op_e while busy=1 is ignored. The pipeline guarantees this cannot happen; RTL must still not corrupt state.
- xaluout, combinational:
  - op_e=8: hi
  - op_e=7: lo
  - otherwise 0
- Reads return committed HI/LO, never pending values.

Optional Feature:
- Macro: MDU_MACC_EN.
- Defined: opcodes 9-12 implemented as above and included in the xstall/start decoding.
- Undefined: opcodes 9-12 behave as 0 (no start, no stall, no state change), and the accumulate datapath is absent.

Test Plan:
- reset; op_e=6, numa=-3, numb=7 (WIDTH=32) -> busy high for 5 cycles, hi/lo unchanged during busy. Then hi=0xFFFFFFFF, lo=0xFFFFFFEB; mfhi/mflo return these.
- op_e=4, numa=-7, numb=2 -> busy for 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu numa=5, numb=0 -> lo=0xFFFFFFFF, hi=5. div numa=0x80000000, numb=-1 -> lo=0x80000000, hi=0.
- Start mult, then op_d=7 in the start cycle and every busy cycle -> xstall=1 from the start cycle through the last busy cycle, and 0 the cycle after. op_d=0 -> xstall=0 throughout.
- Assert reset 2 cycles into a div -> next edge busy=0, hi=lo=0, and no later commit.
- MDU_MACC_EN: mthi 0, mtlo 10, then madd numa=3, numb=4 -> lo=22 after 5 cycles; then msubu 1,22 -> lo=0, hi=0. Without the macro, op_e=9 -> no busy, hi/lo unchanged.
